// File: rtl/riscv_pkg.sv
// Shared RV32I encodings: I-type funct3 codes and the ALU arbiter FSM states.
package riscv_pkg;

    typedef enum logic [2:0] {
        ADDI  = 3'b000,
        SLLI  = 3'b001,
        SLTI  = 3'b010,
        SLTIU = 3'b011,
        XORI  = 3'b100,
        SRI   = 3'b101,
        ORI   = 3'b110,
        ANDI  = 3'b111
    } i_func_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2,
        RESP  = 2'd3
    } alu_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first valid index after i_ptr, wrapping.
module rr_pick #(
    parameter int N    = 2,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    i_valid,
    input  logic [ID_W-1:0] i_ptr,
    output logic            o_any,
    output logic [ID_W-1:0] o_winner
);

    int w_idx;

    // Walk from farthest to nearest so the nearest valid index overwrites the rest.
    always_comb begin
        o_any    = 1'b0;
        o_winner = '0;
        w_idx    = 0;
        for (int i = N; i >= 1; i--) begin
            w_idx = (int'(i_ptr) + i) % N;
            if (i_valid[w_idx]) begin
                o_any    = 1'b1;
                o_winner = ID_W'(w_idx);
            end
        end
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// One RV32I I-type execute unit shared round-robin between NUM_REQ requesters;
// shifts are iterated one bit per cycle instead of using a barrel shifter.
module alu_rr_arbiter
    import riscv_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*3-1:0]    req_func,
    input  logic [NUM_REQ-1:0]      req_alt,
    input  logic [NUM_REQ*XLEN-1:0] req_a,
    input  logic [NUM_REQ*XLEN-1:0] req_b,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [XLEN-1:0]         resp_data
);

    localparam int SH_W = $clog2(XLEN);

    alu_arb_state_t  r_state, w_next;
    logic [ID_W-1:0] r_ptr, r_id, w_win;
    logic            w_any, w_accept, w_is_shift;
    logic [XLEN-1:0] r_a, r_b, r_res, w_alu, w_shifted;
    i_func_t         r_func;
    logic            r_alt;
    logic [SH_W-1:0] r_cnt;

    rr_pick #(.N(NUM_REQ), .ID_W(ID_W)) u_pick (
        .i_valid  (req_valid),
        .i_ptr    (r_ptr),
        .o_any    (w_any),
        .o_winner (w_win)
    );

    assign w_accept   = (r_state == IDLE) && w_any;
    assign w_is_shift = (r_func == SLLI) || (r_func == SRI);
    assign resp_valid = (r_state == RESP);
    assign resp_id    = r_id;
    assign resp_data  = r_res;

    always_comb begin
        req_ready = '0;
        if (w_accept) req_ready[w_win] = 1'b1;
    end

    always_comb begin
        w_alu = '0;
        case (r_func)
            ADDI:    w_alu = r_a + r_b;
            SLTI:    w_alu = {{(XLEN-1){1'b0}}, $signed(r_a) < $signed(r_b)};
            SLTIU:   w_alu = {{(XLEN-1){1'b0}}, r_a < r_b};
            XORI:    w_alu = r_a ^ r_b;
            ORI:     w_alu = r_a | r_b;
            ANDI:    w_alu = r_a & r_b;
            default: w_alu = r_a;
        endcase
    end

    always_comb begin
        w_shifted = r_res;
        if (r_func == SLLI)  w_shifted = {r_res[XLEN-2:0], 1'b0};
        else if (r_alt)      w_shifted = {r_res[XLEN-1], r_res[XLEN-1:1]};
        else                 w_shifted = {1'b0, r_res[XLEN-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  if (w_any) w_next = EXEC;
            EXEC:  w_next = (w_is_shift && (r_b[SH_W-1:0] != '0)) ? SHIFT : RESP;
            SHIFT: if (r_cnt == SH_W'(1)) w_next = RESP;
            RESP:  if (resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr  <= ID_W'(NUM_REQ - 1);
            r_id   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
            r_func <= ADDI;
            r_alt  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_a    <= req_a[w_win*XLEN +: XLEN];
                    r_b    <= req_b[w_win*XLEN +: XLEN];
                    r_func <= i_func_t'(req_func[w_win*3 +: 3]);
                    r_alt  <= req_alt[w_win];
                    r_id   <= w_win;
                    r_ptr  <= w_win;
                end
                EXEC: begin
                    // Shifts seed the result with rs1; only b[4:0] counts as shamt.
                    if (w_is_shift) begin
                        r_res <= r_a;
                        r_cnt <= r_b[SH_W-1:0];
                    end else begin
                        r_res <= w_alu;
                    end
                end
                SHIFT: begin
                    r_res <= w_shifted;
                    r_cnt <= r_cnt - SH_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: ops, latency, shift limits, contention,
// backpressure and reset mid-shift.
module tb_alu_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_alt;
    logic [5:0]  req_func;
    logic [63:0] req_a, req_b;
    logic        resp_valid, resp_ready;
    logic        resp_id;
    logic [31:0] resp_data;

    int checks = 0;
    int errors = 0;

    alu_rr_arbiter #(.NUM_REQ(2), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
        .req_alt(req_alt), .req_a(req_a), .req_b(req_b),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are read 1ns later.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [2:0] f, input logic alt,
                           input logic [31:0] a, input logic [31:0] b);
        req_func[r*3 +: 3] = f;
        req_alt[r]         = alt;
        req_a[r*32 +: 32]  = a;
        req_b[r*32 +: 32]  = b;
    endtask

    task automatic run_op(input string name, input int r, input logic [2:0] f,
                          input logic alt, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_data, input int exp_lat);
        int w;
        int k;
        logic [1:0] exp_rdy;
        exp_rdy = 2'b01 << r;
        resp_ready = 1'b1;
        @(negedge clk);
        set_req(r, f, alt, a, b);
        req_valid[r] = 1'b1;
        #1;
        w = 0;
        while (req_ready == 2'b00 && w < 10) begin step(); w++; end
        checks++;
        if (req_ready !== exp_rdy || w != 0) begin
            errors++;
            $display("FAIL %s grant: req_ready=%b wait=%0d, required %b wait=0", name, req_ready, w, exp_rdy);
        end
        @(negedge clk);
        req_valid[r] = 1'b0;
        #1;
        k = 1;
        while (!resp_valid && k < 40) begin step(); k++; end
        checks++;
        if (k != exp_lat || resp_data !== exp_data || resp_id !== 1'(r)) begin
            errors++;
            $display("FAIL %s result: lat=%0d data=%h id=%b, required lat=%0d data=%h id=%0d",
                     name, k, resp_data, resp_id, exp_lat, exp_data, r);
        end
        step();
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s resp_drop: resp_valid=%b, required 0", name, resp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0; req_func = '0; req_alt = '0; req_a = '0; req_b = '0;
        resp_ready = 1'b0;
        step(); step();
        checks++;
        if (req_ready !== 2'b00 || resp_valid !== 1'b0 || resp_id !== 1'b0 || resp_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b id=%b data=%h, required 00 0 0 0",
                     req_ready, resp_valid, resp_id, resp_data);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_ops();
        run_op("addi",      0, 3'b000, 1'b0, 32'd5,        32'hFFFF_FFFD, 32'd2,          2);
        run_op("slti",      0, 3'b010, 1'b0, 32'd1,        32'hFFFF_FFFF, 32'd0,          2);
        run_op("sltiu",     0, 3'b011, 1'b0, 32'd1,        32'hFFFF_FFFF, 32'd1,          2);
        run_op("xori",      0, 3'b100, 1'b0, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, 2);
        run_op("ori",       0, 3'b110, 1'b0, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 2);
        run_op("andi",      0, 3'b111, 1'b0, 32'h0000_FF0F, 32'h0000_0FF0, 32'h0000_0F00, 2);
        run_op("addi_wrap", 0, 3'b000, 1'b1, 32'hFFFF_FFFF, 32'd1,         32'd0,         2);
    endtask

    task automatic test_shifts();
        run_op("srai4",     0, 3'b101, 1'b1, 32'h8000_0000, 32'd4,       32'hF800_0000, 6);
        run_op("srli4",     0, 3'b101, 1'b0, 32'h8000_0000, 32'd4,       32'h0800_0000, 6);
        run_op("srai_hi",   0, 3'b101, 1'b1, 32'h8000_0000, 32'h404,     32'hF800_0000, 6);
        run_op("slli0",     0, 3'b001, 1'b0, 32'h0000_1234, 32'h20,      32'h0000_1234, 2);
        run_op("slli31",    0, 3'b001, 1'b0, 32'd1,         32'd31,      32'h8000_0000, 33);
    endtask

    task automatic test_back_to_back();
        int w;
        logic exp_id;
        // Restart from reset so requester 0 has first priority.
        test_reset();
        resp_ready = 1'b1;
        set_req(0, 3'b000, 1'b0, 32'd10, 32'd1);
        set_req(1, 3'b000, 1'b0, 32'd20, 32'd2);
        @(negedge clk);
        req_valid = 2'b11;
        #1;
        for (int g = 0; g < 4; g++) begin
            exp_id = 1'(g % 2);
            w = 0;
            while (req_ready == 2'b00 && w < 10) begin step(); w++; end
            checks++;
            if (req_ready !== (2'b01 << exp_id)) begin
                errors++;
                $display("FAIL rr_grant%0d: req_ready=%b, required %b", g, req_ready, 2'b01 << exp_id);
            end
            w = 0;
            step();
            while (!resp_valid && w < 10) begin step(); w++; end
            checks++;
            if (resp_id !== exp_id || resp_data !== (exp_id ? 32'd22 : 32'd11)) begin
                errors++;
                $display("FAIL rr_resp%0d: id=%b data=%h, required id=%b data=%h",
                         g, resp_id, resp_data, exp_id, exp_id ? 32'd22 : 32'd11);
            end
            step();
        end
        @(negedge clk);
        req_valid = 2'b00;
        repeat (3) step();
        run_op("lone_req1", 1, 3'b000, 1'b0, 32'd7, 32'd8, 32'd15, 2);
    endtask

    task automatic test_backpressure();
        int k;
        resp_ready = 1'b0;
        @(negedge clk);
        set_req(0, 3'b000, 1'b0, 32'd100, 32'd23);
        set_req(1, 3'b100, 1'b0, 32'hAAAA_0000, 32'h0000_5555);
        req_valid = 2'b01;
        #1;
        step();
        req_valid = 2'b10;
        k = 0;
        while (!resp_valid && k < 10) begin step(); k++; end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 32'd123 || req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold%0d: vld=%b id=%b data=%h rdy=%b, required 1 0 0000007b 00",
                         c, resp_valid, resp_id, resp_data, req_ready);
            end
            step();
        end
        resp_ready = 1'b1;
        #1;
        checks++;
        if (resp_valid !== 1'b1 || resp_data !== 32'd123 || req_ready !== 2'b00) begin
            errors++;
            $display("FAIL bp_release: vld=%b data=%h rdy=%b, required 1 0000007b 00",
                     resp_valid, resp_data, req_ready);
        end
        step();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_next_grant: vld=%b rdy=%b, required 0 10", resp_valid, req_ready);
        end
        step();
        req_valid = 2'b00;
        k = 0;
        while (!resp_valid && k < 10) begin step(); k++; end
        checks++;
        if (resp_id !== 1'b1 || resp_data !== 32'hAAAA_5555) begin
            errors++;
            $display("FAIL bp_req1_resp: id=%b data=%h, required 1 aaaa5555", resp_id, resp_data);
        end
        step();
    endtask

    task automatic test_reset_mid_shift();
        int seen;
        resp_ready = 1'b1;
        @(negedge clk);
        set_req(0, 3'b101, 1'b1, 32'h8000_0000, 32'd31);
        req_valid = 2'b01;
        #1;
        step();
        req_valid = 2'b00;
        repeat (3) step();
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready !== 2'b00 || resp_valid !== 1'b0 || resp_id !== 1'b0 || resp_data !== 32'h0) begin
            errors++;
            $display("FAIL rst_abort: rdy=%b vld=%b id=%b data=%h, required all 0",
                     req_ready, resp_valid, resp_id, resp_data);
        end
        step();
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            if (resp_valid) seen++;
            step();
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rst_no_resp: resp_valid cycles=%0d, required 0", seen);
        end
        set_req(0, 3'b000, 1'b0, 32'd1, 32'd2);
        set_req(1, 3'b000, 1'b0, 32'd3, 32'd4);
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rst_first_grant: req_ready=%b, required 01", req_ready);
        end
        step();
        req_valid = 2'b00;
        step();
        checks++;
        if (resp_valid !== 1'b1 || resp_id !== 1'b0 || resp_data !== 32'd3) begin
            errors++;
            $display("FAIL rst_post_resp: vld=%b id=%b data=%h, required 1 0 00000003",
                     resp_valid, resp_id, resp_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_ops();
        test_shifts();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time bound");
        $fatal(1, "timeout");
    end

endmodule
